// File: rtl/sna_response_packetizer.sv
// sna_response_packetizer: packs AXI4-Lite B/R responses from a slave into NoC response flits on one router VC
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   bvalid, bresp, bready          AXI4-Lite write response channel (slave side)
//   rvalid, rdata, rresp, rready   AXI4-Lite read response channel (slave side)
//   dest_id                        NoC address of the requesting master, captured with the response
//   is_allocatable, is_on_off      router per-VC flow control; only bit VC_ID is used
//   flit_out, flit_type, flit_valid  registered flit injection (type 01 head, 10 tail, 11 head+tail)
// Build option: define RESP_RR_ARB_EN for round-robin B/R arbitration (default: fixed B priority).
module sna_response_packetizer #(
  parameter int NUM_VC = 8,
  parameter int VC_ID = 0,
  parameter logic [3:0] SRC_ID = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready,
  input  logic              rvalid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  output logic              rready,
  input  logic [3:0]        dest_id,
  input  logic [NUM_VC-1:0] is_allocatable,
  input  logic [NUM_VC-1:0] is_on_off,
  output logic [31:0]       flit_out,
  output logic [1:0]        flit_type,
  output logic              flit_valid
);
  typedef enum logic [1:0] {IDLE, HEAD, DATA} state_t;
  state_t state, state_d;
  logic cap_wr;
  logic [1:0] cap_resp;
  logic [3:0] cap_dest;
  logic [31:0] cap_data;
  logic [31:0] flit_out_d;
  logic [1:0] flit_type_d;
  logic flit_valid_d;
  logic prefer_b, can_head, can_tail, grant, unused_fc;
  assign can_head = is_allocatable[VC_ID] && is_on_off[VC_ID];
  assign can_tail = is_on_off[VC_ID];
  // Other VCs' flow-control bits are deliberately ignored.
  assign unused_fc = ^{is_allocatable, is_on_off};
`ifdef RESP_RR_ARB_EN
  // ptr_r set means R is preferred on the next B/R contention.
  logic ptr_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_r <= 1'b0;
    else if (grant) ptr_r <= bready;
  assign prefer_b = !ptr_r;
`else
  assign prefer_b = 1'b1;
`endif
  assign bready = (state == IDLE) && bvalid && (prefer_b || !rvalid);
  assign rready = (state == IDLE) && rvalid && !(bvalid && prefer_b);
  assign grant = bready || rready;
  always_comb begin
    state_d = state;
    flit_valid_d = 1'b0;
    flit_out_d = 32'd0;
    flit_type_d = 2'b00;
    case (state)
      IDLE: state_d = grant ? HEAD : IDLE;
      HEAD: if (can_head) begin
        flit_valid_d = 1'b1;
        flit_out_d = {cap_dest, SRC_ID, cap_wr, cap_resp, 21'd0};
        flit_type_d = cap_wr ? 2'b11 : 2'b01;
        state_d = cap_wr ? IDLE : DATA;
      end
      DATA: if (can_tail) begin
        flit_valid_d = 1'b1;
        flit_out_d = cap_data;
        flit_type_d = 2'b10;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      flit_valid <= 1'b0;
      flit_out <= 32'd0;
      flit_type <= 2'b00;
      cap_wr <= 1'b0;
      cap_resp <= 2'b00;
      cap_dest <= 4'd0;
      cap_data <= 32'd0;
    end else begin
      state <= state_d;
      flit_valid <= flit_valid_d;
      flit_out <= flit_out_d;
      flit_type <= flit_type_d;
      if (grant) begin
        cap_wr <= bready;
        cap_resp <= bready ? bresp : rresp;
        cap_dest <= dest_id;
        cap_data <= rready ? rdata : 32'd0;
      end
    end
endmodule

// File: tb/tb_sna_response_packetizer.sv
// tb_sna_response_packetizer: checks the response packetizer against a queue-based flit model
module tb_sna_response_packetizer;
  localparam int NUM_VC = 8;
  localparam int VC = 2;
  localparam logic [3:0] SRC = 4'h5;
  typedef struct packed { logic [31:0] d; logic [1:0] t; } flit_s;
  logic clk = 1'b0, rst_n = 1'b0;
  logic bvalid = 1'b0, rvalid = 1'b0, bready, rready, flit_valid;
  logic [1:0] bresp = 2'b00, rresp = 2'b00, flit_type;
  logic [31:0] rdata = 32'd0, flit_out;
  logic [3:0] dest_id = 4'd0;
  logic [NUM_VC-1:0] is_allocatable = '0, is_on_off = '0;
  logic own_a = 1'b1, own_o = 1'b1, rnd = 1'b0, pref_b = 1'b1, got_b = 1'b0, got_r = 1'b0;
  int n_chk = 0, n_fail = 0;
  flit_s exp_q[$];
  flit_s log_q[$];

  always #5 clk = ~clk;

  sna_response_packetizer #(.NUM_VC(NUM_VC), .VC_ID(VC), .SRC_ID(SRC)) dut (
    .clk(clk), .rst_n(rst_n),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .dest_id(dest_id), .is_allocatable(is_allocatable), .is_on_off(is_on_off),
    .flit_out(flit_out), .flit_type(flit_type), .flit_valid(flit_valid)
  );

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic flit_s head(input logic wr, input logic [1:0] resp, input logic [3:0] dst);
    flit_s f;
    f.d = {dst, SRC, wr, resp, 21'd0};
    f.t = wr ? 2'b11 : 2'b01;
    return f;
  endfunction

  // One clock: drive flow control, check readies before the edge, then check flits after it.
  task automatic cycle();
    logic a, o, eb, er, idle, fresh, ev;
    logic [1:0] br, rr;
    logic [3:0] dst;
    logic [31:0] rd;
    flit_s tl;
    if (rnd) begin
      own_a = $urandom_range(0, 3) != 0;
      own_o = $urandom_range(0, 3) != 0;
    end
    is_allocatable = NUM_VC'($urandom);
    is_allocatable[VC] = own_a;
    is_on_off = NUM_VC'($urandom);
    is_on_off[VC] = own_o;
    #1;
    a = own_a; o = own_o; br = bresp; rr = rresp; dst = dest_id; rd = rdata;
    idle = rst_n && exp_q.size() == 0;
    eb = idle && bvalid && (!rvalid || pref_b);
    er = idle && rvalid && !(bvalid && pref_b);
    chk("bready", 34'(bready), 34'(eb));
    chk("rready", 34'(rready), 34'(er));
    @(negedge clk);
    got_b = eb;
    got_r = er;
    fresh = eb || er;
    if (eb) exp_q.push_back(head(1'b1, br, dst));
    if (er) begin
      exp_q.push_back(head(1'b0, rr, dst));
      tl.d = rd;
      tl.t = 2'b10;
      exp_q.push_back(tl);
    end
`ifdef RESP_RR_ARB_EN
    if (fresh) pref_b = er;
`endif
    ev = rst_n && !fresh && exp_q.size() > 0 && (exp_q[0].t[0] ? (a && o) : o);
    chk("flit_valid", 34'(flit_valid), 34'(ev));
    if (ev) begin
      chk("flit", {flit_out, flit_type}, exp_q[0]);
      tl.d = flit_out;
      tl.t = flit_type;
      log_q.push_back(tl);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic send(input logic wr, input logic [1:0] resp, input logic [3:0] dst, input logic [31:0] d);
    bvalid = wr;
    rvalid = !wr;
    dest_id = dst;
    if (wr) bresp = resp;
    else begin
      rresp = resp;
      rdata = d;
    end
    got_b = 1'b0;
    got_r = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (got_b || got_r) break;
    end
    chk("accept_timeout", 34'(got_b || got_r), 34'(1));
    bvalid = 1'b0;
    rvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle();
    chk("drain_timeout", 34'(exp_q.size()), 34'(0));
  endtask

  initial begin
    int nb, nr, n0;
    logic [5:0] order, exp_order;
    @(negedge clk);
    chk("rst_bready", 34'(bready), 34'(0));
    chk("rst_rready", 34'(rready), 34'(0));
    chk("rst_flit_valid", 34'(flit_valid), 34'(0));
    chk("rst_flit_type", 34'(flit_type), 34'(0));
    chk("rst_flit_out", 34'(flit_out), 34'(0));
    rst_n = 1'b1;
    // B and R both held valid for three responses each
    bvalid = 1'b1; rvalid = 1'b1;
    bresp = 2'($urandom); rresp = 2'($urandom); rdata = $urandom; dest_id = 4'($urandom);
    nb = 0; nr = 0; order = '0;
    for (int i = 0; i < 40 && (nb < 3 || nr < 3); i++) begin
      cycle();
      if (got_b) begin
        order = {order[4:0], 1'b1};
        nb++;
        bresp = 2'($urandom);
        dest_id = 4'($urandom);
        if (nb == 3) bvalid = 1'b0;
      end
      if (got_r) begin
        order = {order[4:0], 1'b0};
        nr++;
        rresp = 2'($urandom);
        rdata = $urandom;
        dest_id = 4'($urandom);
        if (nr == 3) rvalid = 1'b0;
      end
    end
    drain();
`ifdef RESP_RR_ARB_EN
    exp_order = 6'b101010;
`else
    exp_order = 6'b111000;
`endif
    chk("arb_order", 34'(order), 34'(exp_order));
    // single write and single read with all credits high
    send(1'b1, 2'b00, 4'h3, 32'd0);
    drain();
    chk("wr_head", log_q[$], {32'h35800000, 2'b11});
    send(1'b0, 2'b00, 4'h2, 32'hDEADBEEF);
    drain();
    chk("rd_head", log_q[$-1], {32'h25000000, 2'b01});
    chk("rd_tail", log_q[$], {32'hDEADBEEF, 2'b10});
    // credit stall on head, then on tail, with a write waiting behind
    own_a = 1'b0;
    send(1'b0, 2'b01, 4'h7, 32'hCAFE0001);
    bvalid = 1'b1; bresp = 2'b11; dest_id = 4'h9;
    n0 = log_q.size();
    repeat (4) cycle();
    chk("stall_head", 34'(log_q.size()), 34'(n0));
    own_a = 1'b1;
    cycle();
    chk("head_after_alloc", 34'(log_q.size()), 34'(n0 + 1));
    own_a = 1'b0; own_o = 1'b0;
    repeat (3) cycle();
    chk("stall_tail", 34'(log_q.size()), 34'(n0 + 1));
    own_o = 1'b1;
    cycle();
    chk("tail_after_onoff", log_q[$], {32'hCAFE0001, 2'b10});
    own_a = 1'b1;
    cycle();
    bvalid = 1'b0;
    drain();
    chk("wr_decerr", log_q[$], {32'h95E00000, 2'b11});
    // random back-to-back traffic under random flow control
    rnd = 1'b1;
    repeat (150) send(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), $urandom);
    rnd = 1'b0; own_a = 1'b1; own_o = 1'b1;
    drain();
    // reset while the tail is pending
    send(1'b0, 2'b00, 4'h1, 32'h12345678);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_flit_valid", 34'(flit_valid), 34'(0));
    chk("midrst_flit_type", 34'(flit_type), 34'(0));
    chk("midrst_flit_out", 34'(flit_out), 34'(0));
    exp_q.delete();
    pref_b = 1'b1;
    repeat (2) cycle();
    rst_n = 1'b1;
    n0 = log_q.size();
    repeat (3) cycle();
    chk("no_tail_after_rst", 34'(log_q.size()), 34'(n0));
    send(1'b1, 2'b01, 4'hC, 32'd0);
    drain();
    chk("post_rst_wr", log_q[$], {32'hC5A00000, 2'b11});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
